block_memory_responder: RTL and testbench

- Main-memory side of the cache refill interface.
- Accepts a 15-bit word address from the cache controller on a valid/ready request channel.
- After a fixed programmable latency, returns the whole aligned 4-word block containing that address on a valid/ready response channel.
- Also provides a single-word write port for testbench preload and store traffic. Memory is word-addressed, 32-bit words.

---
 rtl/block_memory_responder.sv | 157 +++++++++++++++
 tb/tb_block_memory_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_memory_responder.sv
// block_memory_responder
//   Main-memory side of the cache refill interface. A word address arrives
//   on a valid/ready request channel. After LATENCY cycles the aligned
//   4-word block containing it is returned on a valid/ready response
//   channel. A single-word write port serves preload and store traffic.
//
// Parameters
//   ADDR_W   word address width (memory depth 2**ADDR_W 32-bit words)
//   LATENCY  accept edge to first resp_valid edge, legal 1..255
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_addr                    word address, bits [1:0] ignored
//   resp_valid/resp_ready       response handshake
//   resp_addr                   block base address of the served request
//   resp_word0..resp_word3      words base+0..base+3
//   wr_en, wr_addr, wr_data     single-word write port, active in every state
//   served_count                handshake count, saturating
//                               (present only with MM_STATS_EN defined)
//
// Optional feature macro: MM_STATS_EN
module block_memory_responder #(
    parameter int ADDR_W  = 15,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [31:0]       resp_word0,
    output logic [31:0]       resp_word1,
    output logic [31:0]       resp_word2,
    output logic [31:0]       resp_word3,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
`ifdef MM_STATS_EN
    ,
    output logic [15:0]       served_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        cnt;
    logic [7:0]        cnt_next;
    logic [ADDR_W-1:0] base;
    logic              accept;
    logic              sample;

    // Zero at time 0; rst never clears the array.
    logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};

    // Block selection ignores the word offset inside the block.
    logic unused_offset;
    assign unused_offset = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        sample     = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response registers only load on the WAIT->RESP edge, so they stay
    // stable throughout RESP regardless of later writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            resp_addr  <= '0;
            resp_word0 <= '0;
            resp_word1 <= '0;
            resp_word2 <= '0;
            resp_word3 <= '0;
        end else begin
            if (accept) begin
                base <= {req_addr[ADDR_W-1:2], 2'b00};
            end
            if (sample) begin
                resp_addr  <= base;
                resp_word0 <= mem[{base[ADDR_W-1:2], 2'd0}];
                resp_word1 <= mem[{base[ADDR_W-1:2], 2'd1}];
                resp_word2 <= mem[{base[ADDR_W-1:2], 2'd2}];
                resp_word3 <= mem[{base[ADDR_W-1:2], 2'd3}];
            end
        end
    end

    // Writes are honoured even while rst is high. A write on the sample
    // edge lands after the read, so the response carries the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef MM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            served_count <= '0;
        end else if (resp_valid && resp_ready && (served_count != 16'hFFFF)) begin
            served_count <= served_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_block_memory_responder.sv
// Testbench for block_memory_responder: three instances with LATENCY 4, 3
// and 1 share clock and reset. Table-driven block fetches plus directed
// sequences for backpressure, write hazards, mid-flight reset and
// back-to-back traffic. Inputs are driven and outputs sampled on negedge.
module tb_block_memory_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [N];
    logic [14:0] req_addr   [N];
    logic        req_ready  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [14:0] resp_addr  [N];
    logic [31:0] w0 [N];
    logic [31:0] w1 [N];
    logic [31:0] w2 [N];
    logic [31:0] w3 [N];
    logic        wr_en   [N];
    logic [14:0] wr_addr [N];
    logic [31:0] wr_data [N];
`ifdef MM_STATS_EN
    logic [15:0] served [N];
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        block_memory_responder #(
            .ADDR_W (15),
            .LATENCY(g == 0 ? 4 : (g == 1 ? 3 : 1))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_addr  (req_addr[g]),
            .req_ready (req_ready[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_addr (resp_addr[g]),
            .resp_word0(w0[g]),
            .resp_word1(w1[g]),
            .resp_word2(w2[g]),
            .resp_word3(w3[g]),
            .wr_en     (wr_en[g]),
            .wr_addr   (wr_addr[g]),
            .wr_data   (wr_data[g])
`ifdef MM_STATS_EN
            ,
            .served_count(served[g])
`endif
        );
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 4 : ((idx == 1) ? 3 : 1);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[u%0d]: got 0x%08h expected 0x%08h at %0t", name, idx, act, exp, $time);
    endtask

    task automatic chk_block(input string name, input int idx, input logic [14:0] eb,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        chk({name, "_valid"}, idx, 32'(resp_valid[idx]), 32'd1);
        chk({name, "_addr"}, idx, 32'(resp_addr[idx]), 32'(eb));
        chk({name, "_w0"}, idx, w0[idx], e0);
        chk({name, "_w1"}, idx, w1[idx], e1);
        chk({name, "_w2"}, idx, w2[idx], e2);
        chk({name, "_w3"}, idx, w3[idx], e3);
    endtask

    // One write at the next posedge; called at a negedge, returns at a negedge.
    task automatic wr(input int idx, input logic [14:0] a, input logic [31:0] d);
        wr_en[idx]   = 1'b1;
        wr_addr[idx] = a;
        wr_data[idx] = d;
        @(negedge clk);
        wr_en[idx] = 1'b0;
    endtask

    // Full transaction with exact latency check. With wiggle set, req_valid
    // stays high and req_addr moves to other blocks during WAIT.
    task automatic run_txn(input int idx, input logic [14:0] addr, input bit wiggle,
                           input logic [14:0] eb, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3);
        int lat;
        lat = lat_of(idx);
        resp_ready[idx] = 1'b1;
        req_valid[idx]  = 1'b1;
        req_addr[idx]   = addr;
        chk("pre_ready", idx, 32'(req_ready[idx]), 32'd1);
        @(negedge clk);  // after accept edge N
        chk("acc_ready", idx, 32'(req_ready[idx]), 32'd0);
        chk("acc_valid", idx, 32'(resp_valid[idx]), 32'd0);
        if (wiggle) req_addr[idx] = addr ^ 15'h0040;
        else req_valid[idx] = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);  // after edge N+i
            if (i < lat) begin
                chk("wait_valid", idx, 32'(resp_valid[idx]), 32'd0);
                if (wiggle) req_addr[idx] = addr ^ 15'(i * 15'h0100 + 15'h0080);
            end else begin
                chk_block("resp", idx, eb, e0, e1, e2, e3);
                chk("resp_ready_low", idx, 32'(req_ready[idx]), 32'd0);
                req_valid[idx] = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_valid", idx, 32'(resp_valid[idx]), 32'd0);
        chk("done_ready", idx, 32'(req_ready[idx]), 32'd1);
    endtask

    typedef struct {
        int          idx;
        logic [14:0] addr;
        bit          wiggle;
        logic [14:0] base;
        logic [31:0] w [4];
    } vec_t;

    typedef struct {
        int          idx;
        logic [14:0] addr;
        logic [31:0] data;
    } pre_t;

    pre_t pre [15];
    vec_t vec [6];

    initial begin
        bit seen;

        pre[0]  = '{0, 15'h0010, 32'h0000_00A0};
        pre[1]  = '{0, 15'h0011, 32'h0000_00A1};
        pre[2]  = '{0, 15'h0012, 32'h0000_00A2};
        pre[3]  = '{0, 15'h0013, 32'h0000_00A3};
        pre[4]  = '{0, 15'h0014, 32'h1234_5678};
        pre[5]  = '{1, 15'h0100, 32'h0000_0011};
        pre[6]  = '{1, 15'h0101, 32'h0000_0022};
        pre[7]  = '{1, 15'h0102, 32'h0000_0033};
        pre[8]  = '{1, 15'h0103, 32'h0000_0044};
        pre[9]  = '{2, 15'h0040, 32'h0000_00C0};
        pre[10] = '{2, 15'h0041, 32'h0000_00C1};
        pre[11] = '{2, 15'h0044, 32'h0000_00C4};
        pre[12] = '{2, 15'h0045, 32'h0000_00C5};
        pre[13] = '{2, 15'h0046, 32'h0000_00C6};
        pre[14] = '{2, 15'h0047, 32'h0000_00C7};

        vec[0] = '{0, 15'h0012, 1'b0, 15'h0010, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}};
        vec[1] = '{0, 15'h0013, 1'b1, 15'h0010, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}};
        vec[2] = '{0, 15'h0016, 1'b0, 15'h0014, '{32'h1234_5678, 32'h0, 32'h0, 32'h0}};
        vec[3] = '{1, 15'h0101, 1'b1, 15'h0100, '{32'h11, 32'h22, 32'h33, 32'h44}};
        vec[4] = '{2, 15'h0047, 1'b0, 15'h0044, '{32'hC4, 32'hC5, 32'hC6, 32'hC7}};
        vec[5] = '{0, 15'h7FFF, 1'b0, 15'h7FFC, '{32'h0, 32'h0, 32'h0, 32'h0}};

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; resp_ready[i] = 1'b0;
            wr_en[i] = 1'b0; wr_addr[i] = '0; wr_data[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("rst_ready", i, 32'(req_ready[i]), 32'd1);
            chk("rst_valid", i, 32'(resp_valid[i]), 32'd0);
            chk("rst_addr", i, 32'(resp_addr[i]), 32'd0);
            chk("rst_w0", i, w0[i], 32'd0);
            chk("rst_w3", i, w3[i], 32'd0);
        end

        for (int i = 0; i < 15; i++) wr(pre[i].idx, pre[i].addr, pre[i].data);

        for (int i = 0; i < 6; i++)
            run_txn(vec[i].idx, vec[i].addr, vec[i].wiggle, vec[i].base,
                    vec[i].w[0], vec[i].w[1], vec[i].w[2], vec[i].w[3]);

        // Backpressure on the LATENCY=4 instance.
        resp_ready[0] = 1'b0;
        req_valid[0]  = 1'b1;
        req_addr[0]   = 15'h0013;
        @(negedge clk);
        req_valid[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid[0];
        end
        chk("bp_timeout", 0, 32'(seen), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk_block("bp_hold", 0, 15'h0010, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
            chk("bp_ready", 0, 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 0, 32'(resp_valid[0]), 32'd0);
        chk("bp_release_ready", 0, 32'(req_ready[0]), 32'd1);

        // Write hazard on the LATENCY=3 instance: accept at N, sample at N+3.
        resp_ready[1] = 1'b1;
        req_valid[1]  = 1'b1;
        req_addr[1]   = 15'h7FFC;
        @(negedge clk);
        req_valid[1] = 1'b0;
        wr(1, 15'h7FFD, 32'h55);       // lands at N+1
        @(negedge clk);
        wr(1, 15'h7FFE, 32'h66);       // lands at N+3, the sample edge
        chk_block("hz", 1, 15'h7FFC, 32'h0, 32'h55, 32'h0, 32'h0);
        @(negedge clk);
        chk("hz_done", 1, 32'(resp_valid[1]), 32'd0);
        run_txn(1, 15'h7FFE, 1'b0, 15'h7FFC, 32'h0, 32'h55, 32'h66, 32'h0);

        // Reset one cycle after accept, with a write in the reset cycle.
        resp_ready[0] = 1'b1;
        req_valid[0]  = 1'b1;
        req_addr[0]   = 15'h0011;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        wr(0, 15'h0020, 32'hBEEF);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("rstmid_valid", 0, 32'(resp_valid[0]), 32'd0);
            chk("rstmid_ready", 0, 32'(req_ready[0]), 32'd1);
            @(negedge clk);
        end
        run_txn(0, 15'h0010, 1'b0, 15'h0010, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        run_txn(0, 15'h0021, 1'b0, 15'h0020, 32'hBEEF, 32'h0, 32'h0, 32'h0);

        // Back-to-back on LATENCY=1 with req_valid held high.
        resp_ready[2] = 1'b1;
        req_valid[2]  = 1'b1;
        req_addr[2]   = 15'h0041;
        @(negedge clk);  // after N
        chk("b2b_n_ready", 2, 32'(req_ready[2]), 32'd0);
        chk("b2b_n_valid", 2, 32'(resp_valid[2]), 32'd0);
        @(negedge clk);  // after N+1
        chk_block("b2b_first", 2, 15'h0040, 32'hC0, 32'hC1, 32'h0, 32'h0);
        req_addr[2] = 15'h0046;
        @(negedge clk);  // after N+2
        chk("b2b_idle_valid", 2, 32'(resp_valid[2]), 32'd0);
        chk("b2b_idle_ready", 2, 32'(req_ready[2]), 32'd1);
        @(negedge clk);  // after N+3
        chk("b2b_acc2_ready", 2, 32'(req_ready[2]), 32'd0);
        chk("b2b_acc2_valid", 2, 32'(resp_valid[2]), 32'd0);
        req_valid[2] = 1'b0;
        @(negedge clk);  // after N+4
        chk_block("b2b_second", 2, 15'h0044, 32'hC4, 32'hC5, 32'hC6, 32'hC7);
        @(negedge clk);
        chk("b2b_done", 2, 32'(resp_valid[2]), 32'd0);
`ifdef MM_STATS_EN
        chk("served_count", 2, 32'(served[2]), 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
